// File: rtl/bsearch_probe.sv
// Binary-search driver for a magnitude comparator: drives probe onto A and narrows in on the hidden B.
// Optional probe counter output enabled by defining BSEARCH_PROBE_CNT_EN.
module bsearch_probe #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned SETTLE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] probe,
  input  logic             lt,
  input  logic             eq,
  input  logic             gt,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             err,
  output logic [WIDTH-1:0] result
`ifdef BSEARCH_PROBE_CNT_EN
  ,
  output logic [$clog2(WIDTH+2)-1:0] probe_cnt
`endif
);

  localparam int unsigned SCW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [WIDTH-1:0] PROBE0 = {1'b0, {(WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, WAIT, SAMPLE} state_t;

  // Where a freshly driven probe goes: straight to sampling for a combinational comparator.
  localparam state_t FIRST = (SETTLE > 0) ? WAIT : SAMPLE;

  state_t           state;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic [SCW-1:0]   settle_cnt;

  logic             onehot_c;
  logic             hit_c;
  logic             fault_c;
  logic             stop_c;
  logic [WIDTH-1:0] new_lo_c;
  logic [WIDTH-1:0] new_hi_c;
  logic [WIDTH-1:0] mid_c;

  // Flag decode and next probe from the bounds updated in this same cycle.
  always_comb begin
    onehot_c = 1'b0;
    hit_c    = 1'b0;
    fault_c  = 1'b0;
    new_lo_c = lo;
    new_hi_c = hi;
    mid_c    = '0;
    onehot_c = ({lt, eq, gt} == 3'b100) || ({lt, eq, gt} == 3'b010) || ({lt, eq, gt} == 3'b001);
    hit_c    = onehot_c && eq;
    fault_c  = !onehot_c || (lt && (probe == hi)) || (gt && (probe == lo));
    if (lt) new_lo_c = probe + WIDTH'(1);
    if (gt) new_hi_c = probe - WIDTH'(1);
    mid_c    = new_lo_c + ((new_hi_c - new_lo_c) >> 1);
  end

  assign stop_c = hit_c || fault_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lo         <= '0;
      hi         <= '1;
      settle_cnt <= '0;
      probe      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      found      <= 1'b0;
      err        <= 1'b0;
      result     <= '0;
`ifdef BSEARCH_PROBE_CNT_EN
      probe_cnt  <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            lo         <= '0;
            hi         <= '1;
            probe      <= PROBE0;
            busy       <= 1'b1;
            found      <= 1'b0;
            err        <= 1'b0;
            settle_cnt <= SCW'(SETTLE);
            state      <= FIRST;
`ifdef BSEARCH_PROBE_CNT_EN
            probe_cnt  <= '0;
`endif
          end
        end
        WAIT: begin
          settle_cnt <= settle_cnt - SCW'(1);
          if (settle_cnt <= SCW'(1)) state <= SAMPLE;
        end
        SAMPLE: begin
`ifdef BSEARCH_PROBE_CNT_EN
          probe_cnt <= probe_cnt + ($clog2(WIDTH+2))'(1);
`endif
          if (stop_c) begin
            result <= probe;
            found  <= hit_c;
            err    <= fault_c;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            lo         <= new_lo_c;
            hi         <= new_hi_c;
            probe      <= mid_c;
            settle_cnt <= SCW'(SETTLE);
            state      <= FIRST;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bsearch_probe.sv
// Directed bench for bsearch_probe: one instance with SETTLE=0, one with SETTLE=2, behavioural comparators.
`timescale 1ns/1ps
module tb_bsearch_probe;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  bit          sel;
  int          mode;
  logic [15:0] target;

  logic [15:0] probe0, result0, probe2, result2;
  logic        busy0, done0, found0, err0, busy2, done2, found2, err2;
  logic        lt0, eq0, gt0, lt2, eq2, gt2;
  logic        start0, start2;
`ifdef BSEARCH_PROBE_CNT_EN
  logic [4:0]  cnt0, cnt2;
`endif

  int checks = 0;
  int fails  = 0;
  logic [15:0] probes[$];
  int          holds[$];

  always #5 clk = ~clk;

  assign start0 = start && !sel;
  assign start2 = start && sel;

  // mode 0: honest comparator, 1: gt stuck high, 2: lt and eq both high
  always_comb begin
    lt0 = 1'b0; eq0 = 1'b0; gt0 = 1'b0;
    case (mode)
      0: begin lt0 = probe0 < target; eq0 = probe0 == target; gt0 = probe0 > target; end
      1: gt0 = 1'b1;
      default: begin lt0 = 1'b1; eq0 = 1'b1; end
    endcase
  end

  assign lt2 = probe2 < target;
  assign eq2 = probe2 == target;
  assign gt2 = probe2 > target;

  bsearch_probe #(.WIDTH(16), .SETTLE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .probe(probe0), .lt(lt0), .eq(eq0), .gt(gt0),
    .busy(busy0), .done(done0), .found(found0), .err(err0), .result(result0)
`ifdef BSEARCH_PROBE_CNT_EN
    , .probe_cnt(cnt0)
`endif
  );

  bsearch_probe #(.WIDTH(16), .SETTLE(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .probe(probe2), .lt(lt2), .eq(eq2), .gt(gt2),
    .busy(busy2), .done(done2), .found(found2), .err(err2), .result(result2)
`ifdef BSEARCH_PROBE_CNT_EN
    , .probe_cnt(cnt2)
`endif
  );

  function automatic logic [15:0] s_probe();  return sel ? probe2  : probe0;  endfunction
  function automatic logic [15:0] s_result(); return sel ? result2 : result0; endfunction
  function automatic logic s_busy();  return sel ? busy2  : busy0;  endfunction
  function automatic logic s_done();  return sel ? done2  : done0;  endfunction
  function automatic logic s_found(); return sel ? found2 : found0; endfunction
  function automatic logic s_err();   return sel ? err2   : err0;   endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_accept(input logic [15:0] tgt);
    target = tgt;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  // Runs from the cycle after the accept edge until done; lat counts edges including the accept edge.
  task automatic finish_search(input bit spam, output int lat);
    lat = 1;
    probes.delete();
    holds.delete();
    probes.push_back(s_probe());
    holds.push_back(1);
    start = spam;
    while (!s_done() && lat < 300) begin
      tick();
      lat++;
      if (s_done()) start = 1'b0;
      if (s_busy()) begin
        if (s_probe() == probes[probes.size()-1]) holds[holds.size()-1]++;
        else begin
          probes.push_back(s_probe());
          holds.push_back(1);
        end
      end
    end
    start = 1'b0;
    if (lat >= 300) check("timeout", 32'(lat), 32'd0);
  endtask

  initial begin
    int lat;
    int bad;
    int extra_done;
    rst = 1'b1; start = 1'b0; sel = 1'b0; mode = 0; target = 16'h0;
    tick(); tick();
    rst = 1'b0;

    check("rst_probe", 32'(probe0), 32'h0);
    check("rst_busy", 32'(busy0), 32'h0);
    check("rst_done", 32'(done0), 32'h0);
    check("rst_found_err", 32'({found0, err0}), 32'h0);
    check("rst_result", 32'(result0), 32'h0);
    check("rst_probe2", 32'(probe2), 32'h0);

    // Midpoint target: a single sample
    start_accept(16'h7FFF);
    check("mid_busy", 32'(busy0), 32'h1);
    finish_search(1'b0, lat);
    check("mid_lat", 32'(lat), 32'd2);
    check("mid_found", 32'({found0, err0}), 32'h2);
    check("mid_result", 32'(result0), 32'h7FFF);
    check("mid_nprobes", 32'(probes.size()), 32'd1);
    tick();
    check("mid_done_pulse", 32'(done0), 32'h0);
    check("mid_hold", 32'({found0, result0}), 32'h17FFF);

    // Top of range: worst case 17 probes
    start_accept(16'hFFFF);
    finish_search(1'b0, lat);
    check("top_lat", 32'(lat), 32'd18);
    check("top_nprobes", 32'(probes.size()), 32'd17);
    bad = 0;
    for (int i = 0; i < 16 && i < probes.size(); i++)
      if (probes[i] != 16'hFFFF - (16'h8000 >> i)) bad++;
    check("top_seq", 32'(bad), 32'd0);
    if (probes.size() == 17) check("top_last", 32'(probes[16]), 32'hFFFF);
    check("top_found", 32'({found0, err0}), 32'h2);
    check("top_result", 32'(result0), 32'hFFFF);
`ifdef BSEARCH_PROBE_CNT_EN
    check("top_cnt", 32'(cnt0), 32'd17);
    tick();
    check("top_cnt_hold", 32'(cnt0), 32'd17);
`endif

    // Bottom of range through the SETTLE=2 instance
    sel = 1'b1;
    start_accept(16'h0000);
    finish_search(1'b0, lat);
    check("bot_lat", 32'(lat), 32'd49);
    check("bot_nprobes", 32'(probes.size()), 32'd16);
    bad = 0;
    foreach (holds[i]) if (holds[i] != 3) bad++;
    check("bot_hold3", 32'(bad), 32'd0);
    check("bot_last", 32'(probes[probes.size()-1]), 32'h0);
    check("bot_found", 32'({found2, err2}), 32'h2);
    check("bot_result", 32'(result2), 32'h0);
    sel = 1'b0;
    tick();

    // Comparator stuck at gt
    mode = 1;
    start_accept(16'h0000);
    finish_search(1'b0, lat);
    check("gt_lat", 32'(lat), 32'd17);
    check("gt_flags", 32'({found0, err0}), 32'h1);
    check("gt_result", 32'(result0), 32'h0);
    tick();

    // Two flags at once
    mode = 2;
    start_accept(16'h0000);
    finish_search(1'b0, lat);
    check("multi_lat", 32'(lat), 32'd2);
    check("multi_flags", 32'({found0, err0}), 32'h1);
    check("multi_result", 32'(result0), 32'h7FFF);
    mode = 0;
    tick();

    // start held high throughout a search is ignored
    start_accept(16'h1234);
    finish_search(1'b1, lat);
    check("spam_found", 32'({found0, err0}), 32'h2);
    check("spam_result", 32'(result0), 32'h1234);
    extra_done = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (done0) extra_done++; end
    check("spam_single_done", 32'(extra_done), 32'd0);

    // Reset mid-search aborts without done
    start_accept(16'h0F0F);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(busy0), 32'h0);
    check("abort_probe", 32'(probe0), 32'h0);
    check("abort_done", 32'(done0), 32'h0);
    extra_done = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (done0) extra_done++; end
    check("abort_no_done", 32'(extra_done), 32'd0);
    start_accept(16'h0F0F);
    finish_search(1'b0, lat);
    check("after_abort", 32'({found0, err0, result0}), 32'h20F0F);

    // Back-to-back: start in the cycle done is high
    start_accept(16'h00FF);
    finish_search(1'b0, lat);
    check("b2b_first", 32'({found0, result0}), 32'h100FF);
    start_accept(16'hA5A5);
    check("b2b_accept", 32'({busy0, found0, err0}), 32'h4);
    check("b2b_probe0", 32'(probe0), 32'h7FFF);
    finish_search(1'b0, lat);
    check("b2b_second", 32'({found0, err0, result0}), 32'h2A5A5);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
